// File: rtl/des_req_arbiter.sv
// Two-requester front end for a pipelined DES core: round-robin grant, credit-based
// admission and per-requester in-order result FIFOs fed by an in-flight tag FIFO.
module des_req_arbiter #(
  parameter int unsigned RESP_DEPTH = 4,
  parameter int unsigned TAG_DEPTH  = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,

  input  logic        i_r0_valid,
  output logic        o_r0_ready,
  input  logic [63:0] i_r0_data,
  input  logic [63:0] i_r0_key,
  input  logic        i_r0_encrypt,
  output logic        o_r0_res_valid,
  input  logic        i_r0_res_ready,
  output logic [63:0] o_r0_res_data,

  input  logic        i_r1_valid,
  output logic        o_r1_ready,
  input  logic [63:0] i_r1_data,
  input  logic [63:0] i_r1_key,
  input  logic        i_r1_encrypt,
  output logic        o_r1_res_valid,
  input  logic        i_r1_res_ready,
  output logic [63:0] o_r1_res_data,

  output logic [63:0] o_des_cleartext,
  output logic [63:0] o_des_key,
  output logic        o_des_encrypt,
  output logic        o_des_dv,
  input  logic [63:0] i_des_ciphertext,
  input  logic        i_des_dv,
  output logic        o_err
);

  localparam int unsigned OccW   = $clog2(RESP_DEPTH + 1);
  localparam int unsigned RespAw = $clog2(RESP_DEPTH);
  localparam int unsigned TagAw  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned TagCw  = $clog2(TAG_DEPTH + 1);

  localparam logic [OccW-1:0]  OccMax  = OccW'(RESP_DEPTH);
  localparam logic [TagAw-1:0] TagLast = TagAw'(TAG_DEPTH - 1);

  // Per-requester views of the flat port list
  logic [1:0]  req_valid;
  logic [1:0]  res_ready;
  logic [1:0]  res_valid;
  logic [63:0] res_data [2];

  logic [1:0]  elig;
  logic [1:0]  grant;
  logic [1:0]  res_push;
  logic [1:0]  res_pop;
  logic        accept;

  assign req_valid = {i_r1_valid, i_r0_valid};
  assign res_ready = {i_r1_res_ready, i_r0_res_ready};

  assign o_r0_ready     = grant[0];
  assign o_r1_ready     = grant[1];
  assign o_r0_res_valid = res_valid[0];
  assign o_r1_res_valid = res_valid[1];
  assign o_r0_res_data  = res_data[0];
  assign o_r1_res_data  = res_data[1];

  // ---------------------------------------------------------------------------
  // Round-robin grant; rr_last_q = 1 means r1 was granted most recently
  // ---------------------------------------------------------------------------
  logic rr_last_q;

  always_comb begin
    grant    = 2'b00;
    grant[0] = elig[0] && (!elig[1] || rr_last_q);
    grant[1] = elig[1] && (!elig[0] || !rr_last_q);
  end

  assign accept = |grant;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_last_q <= 1'b1;
    end else if (accept) begin
      rr_last_q <= grant[1];
    end
  end

  // ---------------------------------------------------------------------------
  // Core issue registers
  // ---------------------------------------------------------------------------
  logic        des_dv_q;
  logic        des_enc_q;
  logic [63:0] des_data_q;
  logic [63:0] des_key_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      des_dv_q   <= 1'b0;
      des_enc_q  <= 1'b0;
      des_data_q <= '0;
      des_key_q  <= '0;
    end else begin
      des_dv_q <= accept;
      if (accept) begin
        des_enc_q  <= grant[1] ? i_r1_encrypt : i_r0_encrypt;
        des_data_q <= grant[1] ? i_r1_data    : i_r0_data;
        des_key_q  <= grant[1] ? i_r1_key     : i_r0_key;
      end
    end
  end

  assign o_des_dv        = des_dv_q;
  assign o_des_encrypt   = des_enc_q;
  assign o_des_cleartext = des_data_q;
  assign o_des_key       = des_key_q;

  // ---------------------------------------------------------------------------
  // In-flight tag FIFO: requester ID per issued block, popped by core results
  // ---------------------------------------------------------------------------
  logic             tag_mem_q [TAG_DEPTH];
  logic [TagAw-1:0] tag_wptr_q;
  logic [TagAw-1:0] tag_rptr_q;
  logic [TagCw-1:0] tag_cnt_q;
  logic             tag_empty;
  logic             tag_pop;
  logic             tag_head;
  logic             err_q;

  assign tag_empty = (tag_cnt_q == '0);
  assign tag_pop   = i_des_dv && !tag_empty;
  assign tag_head  = tag_mem_q[tag_rptr_q];

  always_ff @(posedge i_clk) begin
    if (accept) begin
      tag_mem_q[tag_wptr_q] <= grant[1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tag_wptr_q <= '0;
      tag_rptr_q <= '0;
      tag_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        tag_wptr_q <= (tag_wptr_q == TagLast) ? '0 : tag_wptr_q + 1'b1;
      end
      if (tag_pop) begin
        tag_rptr_q <= (tag_rptr_q == TagLast) ? '0 : tag_rptr_q + 1'b1;
      end
      tag_cnt_q <= tag_cnt_q + TagCw'(accept) - TagCw'(tag_pop);
      // A result with nothing outstanding is dropped and flagged until reset
      if (i_des_dv && tag_empty) begin
        err_q <= 1'b1;
      end
    end
  end

  assign o_err = err_q;

  // ---------------------------------------------------------------------------
  // Per-requester credit counter and show-ahead result FIFO
  // ---------------------------------------------------------------------------
  for (genvar n = 0; n < 2; n++) begin : g_req
    logic [OccW-1:0]   occ_q;
    logic [OccW-1:0]   occ_d;
    logic [OccW-1:0]   cnt_q;
    logic [RespAw-1:0] wptr_q;
    logic [RespAw-1:0] rptr_q;
    logic [63:0]       mem_q [RESP_DEPTH];

    // Registered occ only: a pop this cycle frees its credit next cycle
    assign elig[n]      = req_valid[n] && (occ_q < OccMax) && !i_rst;
    assign res_valid[n] = (cnt_q != '0);
    assign res_data[n]  = res_valid[n] ? mem_q[rptr_q] : '0;
    assign res_pop[n]   = res_valid[n] && res_ready[n];
    assign res_push[n]  = tag_pop && (tag_head == 1'(n));

    always_comb begin
      occ_d = occ_q + OccW'(grant[n]) - OccW'(res_pop[n]);
    end

    always_ff @(posedge i_clk) begin
      if (res_push[n]) begin
        mem_q[wptr_q] <= i_des_ciphertext;
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        occ_q  <= '0;
        cnt_q  <= '0;
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        occ_q <= occ_d;
        cnt_q <= cnt_q + OccW'(res_push[n]) - OccW'(res_pop[n]);
        if (res_push[n]) begin
          wptr_q <= wptr_q + 1'b1;
        end
        if (res_pop[n]) begin
          rptr_q <= rptr_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_des_req_arbiter.sv
// Directed bench for des_req_arbiter with a behavioural L-stage stand-in for the DES core.
module tb_des_req_arbiter;

  localparam int          L   = 1;
  localparam logic [63:0] Key = 64'h133457799BBCDFF1;
  localparam logic [63:0] Pt  = 64'h0123456789ABCDEF;
  localparam logic [63:0] Ct  = 64'h85E813540F0AB405;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_r0_valid, i_r1_valid;
  logic        o_r0_ready, o_r1_ready;
  logic [63:0] i_r0_data, i_r1_data, i_r0_key, i_r1_key;
  logic        i_r0_encrypt, i_r1_encrypt;
  logic        o_r0_res_valid, o_r1_res_valid;
  logic        i_r0_res_ready, i_r1_res_ready;
  logic [63:0] o_r0_res_data, o_r1_res_data;
  logic [63:0] o_des_cleartext, o_des_key;
  logic        o_des_encrypt, o_des_dv;
  logic [63:0] i_des_ciphertext;
  logic        i_des_dv;
  logic        o_err;
  logic        inj_dv;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp0 [$];
  logic [63:0] exp1 [$];

  always #5 i_clk = ~i_clk;

  des_req_arbiter #(.RESP_DEPTH(4), .TAG_DEPTH(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_r0_valid(i_r0_valid), .o_r0_ready(o_r0_ready), .i_r0_data(i_r0_data),
    .i_r0_key(i_r0_key), .i_r0_encrypt(i_r0_encrypt), .o_r0_res_valid(o_r0_res_valid),
    .i_r0_res_ready(i_r0_res_ready), .o_r0_res_data(o_r0_res_data),
    .i_r1_valid(i_r1_valid), .o_r1_ready(o_r1_ready), .i_r1_data(i_r1_data),
    .i_r1_key(i_r1_key), .i_r1_encrypt(i_r1_encrypt), .o_r1_res_valid(o_r1_res_valid),
    .i_r1_res_ready(i_r1_res_ready), .o_r1_res_data(o_r1_res_data),
    .o_des_cleartext(o_des_cleartext), .o_des_key(o_des_key),
    .o_des_encrypt(o_des_encrypt), .o_des_dv(o_des_dv),
    .i_des_ciphertext(i_des_ciphertext), .i_des_dv(i_des_dv), .o_err(o_err)
  );

  // Core stand-in: the known DES vector both ways, otherwise a reversible scramble
  function automatic logic [63:0] core_fn(input logic [63:0] d, input logic [63:0] k,
                                          input logic e);
    if (e && d == Pt && k == Key) return Ct;
    if (!e && d == Ct && k == Key) return Pt;
    return d ^ k ^ {64{e}};
  endfunction

  logic [L-1:0] pipe_v;
  logic [63:0]  pipe_d [L];

  always @(posedge i_clk) begin
    if (i_rst) begin
      pipe_v <= '0;
    end else begin
      pipe_v[0] <= o_des_dv;
      pipe_d[0] <= core_fn(o_des_cleartext, o_des_key, o_des_encrypt);
      for (int i = 1; i < L; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign i_des_dv         = pipe_v[L-1] | inj_dv;
  assign i_des_ciphertext = pipe_d[L-1];

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    i_r0_valid = 1'b0; i_r1_valid = 1'b0;
    i_r0_res_ready = 1'b0; i_r1_res_ready = 1'b0;
    inj_dv = 1'b0;
    exp0.delete(); exp1.delete();
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({o_r0_ready, o_r1_ready, o_r0_res_valid, o_r1_res_valid} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=0000",
               {o_r0_ready, o_r1_ready, o_r0_res_valid, o_r1_res_valid});
    end
    checks++;
    if ({o_r0_res_data, o_r1_res_data} !== 128'b0) begin
      errors++;
      $display("FAIL reset_res_data got=%h %h exp=0", o_r0_res_data, o_r1_res_data);
    end
    checks++;
    if ({o_des_dv, o_des_encrypt, o_des_cleartext, o_des_key} !== 130'b0) begin
      errors++;
      $display("FAIL reset_des got dv=%b enc=%b pt=%h key=%h exp=0",
               o_des_dv, o_des_encrypt, o_des_cleartext, o_des_key);
    end
    checks++;
    if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", o_err); end
    i_r0_valid = 1'b1; i_r1_valid = 1'b1;
    #1;
    checks++;
    if ({o_r0_ready, o_r1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL reset_first_tie got=%b exp=10", {o_r0_ready, o_r1_ready});
    end
  endtask

  task automatic test_single();
    int lat;
    do_reset();
    @(negedge i_clk);
    i_r0_valid = 1'b1; i_r0_data = Pt; i_r0_key = Key; i_r0_encrypt = 1'b1;
    #1;
    checks++;
    if ({o_r0_ready, o_r1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL single_ready got=%b exp=10", {o_r0_ready, o_r1_ready});
    end
    @(negedge i_clk);
    i_r0_valid = 1'b0;
    checks++;
    if ({o_des_dv, o_des_encrypt, o_des_cleartext, o_des_key} !== {2'b11, Pt, Key}) begin
      errors++;
      $display("FAIL single_issue got dv=%b enc=%b pt=%h key=%h exp dv=1 enc=1 pt=%h key=%h",
               o_des_dv, o_des_encrypt, o_des_cleartext, o_des_key, Pt, Key);
    end
    @(negedge i_clk);
    checks++;
    if (o_des_dv !== 1'b0) begin errors++; $display("FAIL single_dv_pulse got=%b exp=0", o_des_dv); end
    lat = 2;
    while (o_r0_res_valid !== 1'b1 && lat < 20) begin
      @(negedge i_clk);
      lat++;
    end
    checks++;
    if (lat != L + 2) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", lat, L + 2); end
    checks++;
    if (o_r0_res_data !== Ct) begin
      errors++;
      $display("FAIL single_result got=%h exp=%h", o_r0_res_data, Ct);
    end
    checks++;
    if ({o_r1_res_valid, o_err} !== 2'b00) begin
      errors++;
      $display("FAIL single_r1_err got=%b exp=00", {o_r1_res_valid, o_err});
    end
    i_r0_res_ready = 1'b1;
    @(negedge i_clk);
    i_r0_res_ready = 1'b0;
    checks++;
    if (o_r0_res_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pop got=%b exp=0", o_r0_res_valid);
    end
  endtask

  task automatic test_contention();
    logic [63:0] last_pt;
    logic        e0;
    do_reset();
    i_r0_res_ready = 1'b1; i_r1_res_ready = 1'b1;
    i_r0_key = Key; i_r1_key = ~Key; i_r0_encrypt = 1'b1; i_r1_encrypt = 1'b0;
    last_pt = '0;
    for (int c = 0; c < 16; c++) begin
      @(negedge i_clk);
      if (o_r0_res_valid) begin
        checks++;
        if (exp0.size() == 0 || o_r0_res_data !== exp0[0]) begin
          errors++;
          $display("FAIL cont_res0 got=%h exp=%h", o_r0_res_data,
                   exp0.size() != 0 ? exp0[0] : 64'hx);
        end
        if (exp0.size() != 0) void'(exp0.pop_front());
      end
      if (o_r1_res_valid) begin
        checks++;
        if (exp1.size() == 0 || o_r1_res_data !== exp1[0]) begin
          errors++;
          $display("FAIL cont_res1 got=%h exp=%h", o_r1_res_data,
                   exp1.size() != 0 ? exp1[0] : 64'hx);
        end
        if (exp1.size() != 0) void'(exp1.pop_front());
      end
      if (c >= 1 && c <= 8) begin
        checks++;
        if (o_des_dv !== 1'b1 || o_des_cleartext !== last_pt) begin
          errors++;
          $display("FAIL cont_issue c=%0d got dv=%b pt=%h exp dv=1 pt=%h",
                   c, o_des_dv, o_des_cleartext, last_pt);
        end
      end
      i_r0_valid = (c < 8); i_r1_valid = (c < 8);
      i_r0_data = 64'h1000_0000_0000_0000 + 64'(c);
      i_r1_data = 64'h2000_0000_0000_0000 + 64'(c);
      #1;
      if (c < 8) begin
        e0 = (c % 2 == 0);
        checks++;
        if ({o_r0_ready, o_r1_ready} !== {e0, !e0}) begin
          errors++;
          $display("FAIL cont_grant c=%0d got=%b exp=%b", c, {o_r0_ready, o_r1_ready}, {e0, !e0});
        end
      end
      if (o_r0_ready) begin exp0.push_back(core_fn(i_r0_data, Key, 1'b1)); last_pt = i_r0_data; end
      if (o_r1_ready) begin exp1.push_back(core_fn(i_r1_data, ~Key, 1'b0)); last_pt = i_r1_data; end
    end
    checks++;
    if (exp0.size() != 0 || exp1.size() != 0) begin
      errors++;
      $display("FAIL cont_drain left0=%0d left1=%0d exp=0 0", exp0.size(), exp1.size());
    end
  endtask

  task automatic test_backpressure();
    logic e0, e1;
    do_reset();
    i_r0_res_ready = 1'b1; i_r1_res_ready = 1'b0;
    i_r0_key = Key; i_r1_key = Key; i_r0_encrypt = 1'b1; i_r1_encrypt = 1'b1;
    for (int c = 0; c < 26; c++) begin
      @(negedge i_clk);
      if (c == 16) i_r1_res_ready = 1'b1;
      if (o_r0_res_valid && i_r0_res_ready) begin
        checks++;
        if (exp0.size() == 0 || o_r0_res_data !== exp0[0]) begin
          errors++;
          $display("FAIL bp_res0 got=%h exp=%h", o_r0_res_data,
                   exp0.size() != 0 ? exp0[0] : 64'hx);
        end
        if (exp0.size() != 0) void'(exp0.pop_front());
      end
      if (o_r1_res_valid && i_r1_res_ready) begin
        checks++;
        if (exp1.size() == 0 || o_r1_res_data !== exp1[0]) begin
          errors++;
          $display("FAIL bp_res1 got=%h exp=%h", o_r1_res_data,
                   exp1.size() != 0 ? exp1[0] : 64'hx);
        end
        if (exp1.size() != 0) void'(exp1.pop_front());
      end
      i_r0_valid = (c < 18); i_r1_valid = (c < 18);
      i_r0_data = 64'h3000_0000_0000_0000 + 64'(c);
      i_r1_data = 64'h4000_0000_0000_0000 + 64'(c);
      #1;
      if (c < 18) begin
        if (c < 8) begin
          e0 = (c % 2 == 0); e1 = !e0;
        end else if (c < 17) begin
          e0 = 1'b1; e1 = 1'b0;
        end else begin
          e0 = 1'b0; e1 = 1'b1;
        end
        checks++;
        if ({o_r0_ready, o_r1_ready} !== {e0, e1}) begin
          errors++;
          $display("FAIL bp_grant c=%0d got=%b exp=%b", c, {o_r0_ready, o_r1_ready}, {e0, e1});
        end
      end
      if (o_r0_ready) exp0.push_back(core_fn(i_r0_data, Key, 1'b1));
      if (o_r1_ready) exp1.push_back(core_fn(i_r1_data, Key, 1'b1));
    end
    checks++;
    if (exp0.size() != 0 || exp1.size() != 0) begin
      errors++;
      $display("FAIL bp_drain left0=%0d left1=%0d exp=0 0", exp0.size(), exp1.size());
    end
  endtask

  task automatic test_decrypt();
    int lat;
    do_reset();
    @(negedge i_clk);
    i_r1_valid = 1'b1; i_r1_data = Ct; i_r1_key = Key; i_r1_encrypt = 1'b0;
    #1;
    checks++;
    if ({o_r0_ready, o_r1_ready} !== 2'b01) begin
      errors++;
      $display("FAIL dec_ready got=%b exp=01", {o_r0_ready, o_r1_ready});
    end
    @(negedge i_clk);
    i_r1_valid = 1'b0;
    checks++;
    if ({o_des_dv, o_des_encrypt, o_des_cleartext} !== {2'b10, Ct}) begin
      errors++;
      $display("FAIL dec_issue got dv=%b enc=%b pt=%h exp dv=1 enc=0 pt=%h",
               o_des_dv, o_des_encrypt, o_des_cleartext, Ct);
    end
    lat = 1;
    while (o_r1_res_valid !== 1'b1 && lat < 20) begin
      @(negedge i_clk);
      lat++;
    end
    checks++;
    if (o_r1_res_valid !== 1'b1 || o_r1_res_data !== Pt) begin
      errors++;
      $display("FAIL dec_result got valid=%b data=%h exp valid=1 data=%h",
               o_r1_res_valid, o_r1_res_data, Pt);
    end
    checks++;
    if (o_r0_res_valid !== 1'b0) begin
      errors++;
      $display("FAIL dec_r0_quiet got=%b exp=0", o_r0_res_valid);
    end
  endtask

  task automatic test_credit();
    do_reset();
    i_r0_key = Key; i_r0_encrypt = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      i_r0_valid = 1'b1;
      i_r0_data = 64'h5000_0000_0000_0000 + 64'(c);
      #1;
      checks++;
      if (o_r0_ready !== (c < 4)) begin
        errors++;
        $display("FAIL credit_fill c=%0d got=%b exp=%b", c, o_r0_ready, (c < 4));
      end
    end
    @(negedge i_clk);
    i_r0_valid = 1'b0;
    repeat (4) @(negedge i_clk);
    i_r0_valid = 1'b1; i_r0_res_ready = 1'b1;
    #1;
    checks++;
    if ({o_r0_ready, o_r0_res_valid} !== 2'b01) begin
      errors++;
      $display("FAIL credit_same_cycle got ready=%b res_valid=%b exp ready=0 res_valid=1",
               o_r0_ready, o_r0_res_valid);
    end
    checks++;
    if (o_r0_res_data !== core_fn(64'h5000_0000_0000_0000, Key, 1'b1)) begin
      errors++;
      $display("FAIL credit_head got=%h exp=%h", o_r0_res_data,
               core_fn(64'h5000_0000_0000_0000, Key, 1'b1));
    end
    @(negedge i_clk);
    i_r0_res_ready = 1'b0;
    #1;
    checks++;
    if (o_r0_ready !== 1'b1) begin
      errors++;
      $display("FAIL credit_next_cycle got=%b exp=1", o_r0_ready);
    end
    @(negedge i_clk);
    i_r0_valid = 1'b0;
  endtask

  task automatic test_error_reset();
    i_r0_res_ready = 1'b1;
    repeat (6) @(negedge i_clk);
    i_r0_res_ready = 1'b0;
    checks++;
    if ({o_err, o_r0_res_valid} !== 2'b00) begin
      errors++;
      $display("FAIL err_pre got err=%b res_valid=%b exp 0 0", o_err, o_r0_res_valid);
    end
    @(negedge i_clk);
    inj_dv = 1'b1;
    @(negedge i_clk);
    inj_dv = 1'b0;
    checks++;
    if ({o_err, o_r0_res_valid, o_r1_res_valid} !== 3'b100) begin
      errors++;
      $display("FAIL err_set got=%b exp=100", {o_err, o_r0_res_valid, o_r1_res_valid});
    end
    @(negedge i_clk);
    checks++;
    if (o_err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", o_err); end
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    checks++;
    if ({o_err, o_r0_ready, o_r1_ready, o_r0_res_valid, o_r1_res_valid, o_des_dv,
         o_des_encrypt} !== 7'b0 || {o_des_cleartext, o_des_key} !== 128'b0) begin
      errors++;
      $display("FAIL err_reset got err=%b rdy=%b%b rv=%b%b dv=%b enc=%b pt=%h key=%h exp all 0",
               o_err, o_r0_ready, o_r1_ready, o_r0_res_valid, o_r1_res_valid, o_des_dv,
               o_des_encrypt, o_des_cleartext, o_des_key);
    end
    i_r0_valid = 1'b1; i_r1_valid = 1'b1;
    #1;
    checks++;
    if ({o_r0_ready, o_r1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL err_reset_tie got=%b exp=10", {o_r0_ready, o_r1_ready});
    end
    @(negedge i_clk);
    i_r0_valid = 1'b0; i_r1_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1;
    i_r0_valid = 1'b0; i_r1_valid = 1'b0;
    i_r0_data = '0; i_r1_data = '0; i_r0_key = '0; i_r1_key = '0;
    i_r0_encrypt = 1'b0; i_r1_encrypt = 1'b0;
    i_r0_res_ready = 1'b0; i_r1_res_ready = 1'b0;
    inj_dv = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_decrypt();
    test_credit();
    test_error_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
